ps2_host_tx: RTL

- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED (set LEDs) or 0xFF (reset).
- Counterpart to the existing keyboard receive path. Lives in the clk_100 domain beside the keyboard block.
- Drives the bidirectional PS/2 clock and data lines through open-drain enables. The top level builds each pad as: low when the enable is 1, high-Z otherwise.
- Asserts busy while a frame is in flight, so the receiver can ignore that bus activity.

---
 rtl/ps2_host_tx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (open-drain clock/data enables)
// Optional PS2_TX_FILTER_EN: glitch filter on the synchronised device clock before edge detection.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES    = 10000,
  parameter int START_HOLD_CYCLES = 200,
  parameter int TIMEOUT_CYCLES    = 2000000
`ifdef PS2_TX_FILTER_EN
  ,
  parameter int FILTER_LEN        = 4
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W  = $clog2(INHIBIT_CYCLES) + 1;
  localparam int HOLD_W = $clog2(START_HOLD_CYCLES) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE, S_ERROR
  } state_t;

  state_t            state;
  logic [1:0]        clk_sync;
  logic [1:0]        data_sync;
  logic              clk_s;
  logic              data_s;
  logic              clk_lvl;
  logic              clk_prev;
  logic              fe;
  logic              timed;
  logic              to_hit;
  logic [INH_W-1:0]  inh_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [3:0]        bit_cnt;
  logic [9:0]        frame;

  // Synchronisers reset to the idle (released, high) bus level so no edge is seen after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

`ifdef PS2_TX_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN) + 1;

  logic [FLT_W-1:0] flt_cnt;
  logic             flt_lvl;

  // The level only flips after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flt_lvl <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s == flt_lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
      flt_lvl <= clk_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  assign clk_lvl = flt_lvl;
`else
  assign clk_lvl = clk_s;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clk_prev <= 1'b1;
    else          clk_prev <= clk_lvl;
  end

  assign fe = clk_prev & ~clk_lvl;

  // A falling edge on the terminal count cycle keeps the frame alive.
  assign timed  = (state == S_SEND) || (state == S_ACK) || ((state == S_WAIT_IDLE) && !tx_done);
  assign to_hit = timed && !fe && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      busy        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      inh_cnt     <= '0;
      hold_cnt    <= '0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      frame       <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (to_hit) begin
        to_cnt      <= '0;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_error    <= 1'b1;
        state       <= S_ERROR;
      end else begin
        case (state)
          S_IDLE: begin
            if (tx_valid && tx_ready) begin
              frame      <= {1'b1, ~^tx_data, tx_data};
              inh_cnt    <= '0;
              ps2_clk_oe <= 1'b1;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              state      <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
              inh_cnt     <= '0;
              hold_cnt    <= '0;
              ps2_data_oe <= 1'b1;
              state       <= S_START;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          S_START: begin
            if (hold_cnt == HOLD_W'(START_HOLD_CYCLES - 1)) begin
              hold_cnt   <= '0;
              ps2_clk_oe <= 1'b0;
              bit_cnt    <= '0;
              to_cnt     <= '0;
              state      <= S_SEND;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          S_SEND: begin
            to_cnt <= fe ? '0 : to_cnt + 1'b1;
            if (fe) begin
              ps2_data_oe <= ~frame[0];
              frame       <= {1'b0, frame[9:1]};
              bit_cnt     <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd9) state <= S_ACK;
            end
          end
          S_ACK: begin
            to_cnt <= fe ? '0 : to_cnt + 1'b1;
            if (fe) begin
              if (data_s) begin
                ps2_data_oe <= 1'b0;
                tx_error    <= 1'b1;
                state       <= S_ERROR;
              end else begin
                state <= S_WAIT_IDLE;
              end
            end
          end
          S_WAIT_IDLE: begin
            // tx_done is high for the last WAIT_IDLE cycle; ready follows one cycle later.
            if (tx_done) begin
              to_cnt   <= '0;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              to_cnt <= fe ? '0 : to_cnt + 1'b1;
              if (clk_s && data_s) tx_done <= 1'b1;
            end
          end
          S_ERROR: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
